// File: rtl/top_design.sv
// ---------------------------------------------------------------------------
// top_design : synchronous first-word fall-through FIFO
//
// Storage array plus a small controller holding the write pointer, read
// pointer and registered FULL/EMPTY flags.  RD_DATA is driven combinationally
// from the word at the read pointer, so the head of the FIFO is visible with
// zero latency.  RD only advances the read pointer.
//
// Optional build macro: TOP_DESIGN_LEVEL_EN adds the LEVEL output, a
// registered occupancy count (0..depth).
//
// Parameters
//   DATA_WIDTH : word width of WR_DATA, RD_DATA and storage
//   ADDR_WIDTH : pointer width, depth = 2**ADDR_WIDTH words
//
// Ports
//   i_CLK    in   clock, all state updates on the rising edge
//   i_RST_n  in   synchronous active-low reset (clears pointers, flags, storage)
//   WR       in   push request
//   RD       in   pop request
//   WR_DATA  in   word to push
//   RD_DATA  out  word at the head of the FIFO
//   FULL     out  all words occupied
//   EMPTY    out  no words occupied
//   LEVEL    out  occupancy count (TOP_DESIGN_LEVEL_EN builds only)
// ---------------------------------------------------------------------------
module top_design #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_n,
  input  logic                  WR,
  input  logic                  RD,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY
`ifdef TOP_DESIGN_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   LEVEL
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic                  r_full;
  logic                  r_empty;

  logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
  logic                  w_wr_only;
  logic                  w_rd_only;
  logic                  w_both;
  logic                  w_mem_we;

  // Pointers are exactly ADDR_WIDTH bits wide, so the +1 wraps depth-1 -> 0.
  assign w_wr_ptr_nxt = r_wr_ptr + ADDR_WIDTH'(1);
  assign w_rd_ptr_nxt = r_rd_ptr + ADDR_WIDTH'(1);

  // A simultaneous push/pop is only honoured when the FIFO is neither full
  // nor empty; at either boundary the pair is dropped entirely.
  assign w_wr_only = WR & ~RD & ~r_full;
  assign w_rd_only = RD & ~WR & ~r_empty;
  assign w_both    = WR &  RD & ~r_full & ~r_empty;
  assign w_mem_we  = w_wr_only | w_both;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[r_wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_only) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_empty  <= 1'b0;
        r_full   <= (w_wr_ptr_nxt == r_rd_ptr);
      end else if (w_rd_only) begin
        r_rd_ptr <= w_rd_ptr_nxt;
        r_full   <= 1'b0;
        r_empty  <= (w_rd_ptr_nxt == r_wr_ptr);
      end else if (w_both) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_rd_ptr <= w_rd_ptr_nxt;
      end
    end
  end

`ifdef TOP_DESIGN_LEVEL_EN
  logic [ADDR_WIDTH:0] r_level;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      r_level <= '0;
    end else if (w_wr_only) begin
      r_level <= r_level + (ADDR_WIDTH+1)'(1);
    end else if (w_rd_only) begin
      r_level <= r_level - (ADDR_WIDTH+1)'(1);
    end
  end

  assign LEVEL = r_level;
`endif

  assign RD_DATA = r_mem[r_rd_ptr];
  assign FULL    = r_full;
  assign EMPTY   = r_empty;

endmodule

// File: tb/tb_top_design.sv
// ---------------------------------------------------------------------------
// tb_top_design : self-checking bench for top_design
//
// A queue holds the expected FIFO contents; push/pop rules are applied to it
// directly.  Inputs change just after the falling edge, outputs are sampled
// on the falling edge.  Define TOP_DESIGN_LEVEL_EN for both files to exercise
// the LEVEL output.
// ---------------------------------------------------------------------------
module tb_top_design;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          i_CLK;
  logic          i_RST_n;
  logic          WR;
  logic          RD;
  logic [DW-1:0] WR_DATA;
  logic [DW-1:0] RD_DATA;
  logic          FULL;
  logic          EMPTY;
`ifdef TOP_DESIGN_LEVEL_EN
  logic [AW:0]   LEVEL;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_q [$];

  top_design #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_CLK   (i_CLK),
    .i_RST_n (i_RST_n),
    .WR      (WR),
    .RD      (RD),
    .WR_DATA (WR_DATA),
    .RD_DATA (RD_DATA),
    .FULL    (FULL),
`ifdef TOP_DESIGN_LEVEL_EN
    .EMPTY   (EMPTY),
    .LEVEL   (LEVEL)
`else
    .EMPTY   (EMPTY)
`endif
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // One clock with the given requests; model updated from its pre-edge state.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
    bit m_full;
    bit m_empty;
    WR = wr;
    RD = rd;
    WR_DATA = d;
    @(posedge i_CLK);
    m_full  = (m_q.size() == DEPTH);
    m_empty = (m_q.size() == 0);
    if (wr && !rd && !m_full) begin
      m_q.push_back(d);
    end else if (rd && !wr && !m_empty) begin
      void'(m_q.pop_front());
    end else if (wr && rd && !m_full && !m_empty) begin
      void'(m_q.pop_front());
      m_q.push_back(d);
    end
    @(negedge i_CLK);
    WR = 1'b0;
    RD = 1'b0;
    WR_DATA = $urandom();
  endtask

  task automatic apply_reset(input logic wr, input logic rd);
    i_RST_n = 1'b0;
    WR = wr;
    RD = rd;
    WR_DATA = $urandom();
    @(posedge i_CLK);
    m_q.delete();
    @(negedge i_CLK);
    i_RST_n = 1'b1;
    WR = 1'b0;
    RD = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b0, 1'b0);
    checks++;
    if (EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty got %b want 1", EMPTY);
    end
    checks++;
    if (FULL !== 1'b0) begin
      errors++;
      $display("FAIL reset_full got %b want 0", FULL);
    end
    checks++;
    if (RD_DATA !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd_data got %h want 00", RD_DATA);
    end
`ifdef TOP_DESIGN_LEVEL_EN
    checks++;
    if (LEVEL !== 4'd0) begin
      errors++;
      $display("FAIL reset_level got %0d want 0", LEVEL);
    end
`endif
  endtask

  task automatic test_directed();
    logic [DW-1:0] wr_seq [6] = '{8'hAF, 8'hBA, 8'h5A, 8'h41, 8'h50, 8'h12};
    logic [DW-1:0] fill   [3] = '{8'hFC, 8'hEE, 8'hAF};
    logic [DW-1:0] drain  [8] = '{8'h5A, 8'h41, 8'h50, 8'h12, 8'h00, 8'hFC, 8'hEE, 8'hAF};

    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, wr_seq[i]);
      checks++;
      if (EMPTY !== 1'b0 || FULL !== 1'b0 || RD_DATA !== 8'hAF) begin
        errors++;
        $display("FAIL dir_write%0d got empty=%b full=%b rd=%h want 0 0 af", i, EMPTY, FULL, RD_DATA);
      end
    end

    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (RD_DATA !== 8'hBA) begin
      errors++;
      $display("FAIL dir_pop got %h want ba", RD_DATA);
    end

    step(1'b1, 1'b1, 8'h00);
    checks++;
    if (RD_DATA !== 8'h5A || m_q.size() != 5 || FULL !== 1'b0 || EMPTY !== 1'b0) begin
      errors++;
      $display("FAIL dir_wr_rd got rd=%h full=%b empty=%b occ=%0d want 5a 0 0 5", RD_DATA, FULL, EMPTY, m_q.size());
    end

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, fill[i]);
      checks++;
      if (FULL !== (i == 2) || RD_DATA !== 8'h5A) begin
        errors++;
        $display("FAIL dir_fill%0d got full=%b rd=%h want %b 5a", i, FULL, RD_DATA, (i == 2));
      end
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i >= 2), 8'h00);
      checks++;
      if (FULL !== 1'b1 || EMPTY !== 1'b0 || RD_DATA !== 8'h5A) begin
        errors++;
        $display("FAIL dir_full_ignore%0d got full=%b empty=%b rd=%h want 1 0 5a", i, FULL, EMPTY, RD_DATA);
      end
    end

    for (int i = 0; i < 8; i++) begin
      checks++;
      if (RD_DATA !== drain[i]) begin
        errors++;
        $display("FAIL dir_drain%0d got %h want %h", i, RD_DATA, drain[i]);
      end
      step(1'b0, 1'b1, 8'h00);
    end
    checks++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
      errors++;
      $display("FAIL dir_drained got empty=%b full=%b want 1 0", EMPTY, FULL);
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b1 & (i >= 2), 1'b1, 8'h77);
      checks++;
      if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
        errors++;
        $display("FAIL dir_empty_ignore%0d got empty=%b full=%b want 1 0", i, EMPTY, FULL);
      end
    end
`ifdef TOP_DESIGN_LEVEL_EN
    checks++;
    if (LEVEL !== 4'd0) begin
      errors++;
      $display("FAIL dir_level got %0d want 0", LEVEL);
    end
`endif
  endtask

  // Biased random traffic; bias shifts per phase so both boundaries are hit.
  task automatic test_random();
    int wr_pct;
    int rd_pct;
    for (int n = 0; n < 600; n++) begin
      case ((n / 100) % 3)
        0:       begin wr_pct = 75; rd_pct = 30; end
        1:       begin wr_pct = 30; rd_pct = 75; end
        default: begin wr_pct = 55; rd_pct = 55; end
      endcase
      step($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct, DW'($urandom()));
      checks++;
      if (FULL !== (m_q.size() == DEPTH) || EMPTY !== (m_q.size() == 0)) begin
        errors++;
        $display("FAIL rand_flags cyc %0d got full=%b empty=%b want occ %0d", n, FULL, EMPTY, m_q.size());
      end
      if (m_q.size() != 0) begin
        checks++;
        if (RD_DATA !== m_q[0]) begin
          errors++;
          $display("FAIL rand_head cyc %0d got %h want %h", n, RD_DATA, m_q[0]);
        end
      end
`ifdef TOP_DESIGN_LEVEL_EN
      checks++;
      if (LEVEL !== (AW+1)'(m_q.size())) begin
        errors++;
        $display("FAIL rand_level cyc %0d got %0d want %0d", n, LEVEL, m_q.size());
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        apply_reset(1'b1, 1'b0);
        checks++;
        if (EMPTY !== 1'b1 || FULL !== 1'b0 || RD_DATA !== 8'h00) begin
          errors++;
          $display("FAIL mid_reset got empty=%b full=%b rd=%h want 1 0 00", EMPTY, FULL, RD_DATA);
        end
      end
      step(1'b1, 1'b0, 8'h10 + DW'(i));
`ifdef TOP_DESIGN_LEVEL_EN
      checks++;
      if (LEVEL !== (AW+1)'(m_q.size())) begin
        errors++;
        $display("FAIL mid_level%0d got %0d want %0d", i, LEVEL, m_q.size());
      end
`endif
    end
    checks++;
    if (RD_DATA !== 8'h15 || m_q.size() != 3 || EMPTY !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got rd=%h empty=%b want 15 0", RD_DATA, EMPTY);
    end
    while (m_q.size() < DEPTH) step(1'b1, 1'b0, DW'($urandom()));
`ifdef TOP_DESIGN_LEVEL_EN
    checks++;
    if (LEVEL !== 4'd8) begin
      errors++;
      $display("FAIL mid_level_full got %0d want 8", LEVEL);
    end
`endif
    apply_reset(1'b1, 1'b1);
    checks++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0 || RD_DATA !== 8'h00) begin
      errors++;
      $display("FAIL full_reset got empty=%b full=%b rd=%h want 1 0 00", EMPTY, FULL, RD_DATA);
    end
`ifdef TOP_DESIGN_LEVEL_EN
    checks++;
    if (LEVEL !== 4'd0) begin
      errors++;
      $display("FAIL full_reset_level got %0d want 0", LEVEL);
    end
`endif
  endtask

  // Reset pulsed low entirely between rising edges must not disturb state.
  task automatic test_reset_glitch();
    step(1'b1, 1'b0, 8'hC3);
    step(1'b1, 1'b0, 8'h3C);
    #1 i_RST_n = 1'b0;
    #2 i_RST_n = 1'b1;
    @(negedge i_CLK);
    checks++;
    if (EMPTY !== 1'b0 || RD_DATA !== 8'hC3) begin
      errors++;
      $display("FAIL glitch got empty=%b rd=%h want 0 c3", EMPTY, RD_DATA);
    end
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (RD_DATA !== 8'h3C) begin
      errors++;
      $display("FAIL glitch_pop got %h want 3c", RD_DATA);
    end
  endtask

  initial begin
    i_RST_n = 1'b1;
    WR      = 1'b0;
    RD      = 1'b0;
    WR_DATA = '0;
    @(negedge i_CLK);
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_reset_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
